ej32_ss_ctl: RTL and testbench
==============================

# ej32_ss_ctl

Data-stack controller for the eJ32 arithmetic unit. It owns the data-stack pointer, depth count, cached NOS register and the read/write port controls of the dual-port EBR that backs the stack. The AU issues one stack op per cycle and receives NOS back. The block resolves read-after-write hazards with a one-entry bypass, stalls the AU with a busy flag while a refill read is outstanding, and records overflow and underflow in sticky error flags.

## Interface
- SS_DEPTH, 32: number of EBR stack entries. Must be a power of 2.
- ASZ, 5: EBR address width, log2(SS_DEPTH).
- DSZ, 32: data width.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  AU enable. When low, all state is frozen.
- op_i  in  2  stack op: 0 NOP, 1 PUSH, 2 POP, 3 SWAP.
- t_i  in  DSZ  current TOS from the control bus.
- err_clr  in  1  clears the sticky error flags.
- rd_data_i  in  DSZ  EBR read data. Valid one cycle after a read is issued.
- ss_ren  out  1  EBR read enable.
- ss_wen  out  1  EBR write enable.
- ss_raddr  out  ASZ  EBR read address.
- ss_waddr  out  ASZ  EBR write address.
- ss_wdata  out  DSZ  EBR write data.
- s_o  out  DSZ  NOS register.
- bsy_o  out  1  refill in progress. Ops are not accepted while high.
- depth_o  out  ASZ+1  number of items below TOS, 0..SS_DEPTH+1.
- full_o  out  1  depth_o == SS_DEPTH+1.
- empty_o  out  1  depth_o == 0.
- ovf_o  out  1  sticky: PUSH attempted while full.
- unf_o  out  1  sticky: POP attempted while empty.

## Operation
- Storage model: TOS lives outside this block, NOS lives in register s, and older items live in the EBR at addresses 0..sp-1. Total capacity below TOS is SS_DEPTH+1.
- Accept condition: accept = en & !bsy_o & op_i != NOP. Ops presented while bsy_o is high are ignored, and the caller holds them.
- PUSH, not full:
  - If depth ≥ 1: drive ss_wen=1, ss_waddr=sp, ss_wdata=s; then sp<=sp+1, byp<=s, byp_vld<=1.
  - Always: s<=t_i and depth+1.
- PUSH while full: no state change except ovf<=1. ss_wen stays 0.
- POP with depth==1: depth<=0 and s<=0. No EBR access.
- POP with depth≥2 and byp_vld=1: s<=byp, sp<=sp-1, depth-1, byp_vld<=0. No read and no stall.
- POP with depth≥2 and byp_vld=0: drive ss_ren=1, ss_raddr=sp-1; then sp<=sp-1, depth-1, and move to FILL.
- POP while empty: no state change except unf<=1.
- SWAP: s<=t_i, with no pointer or depth change. The AU loads TOS from s_o in the same cycle.
- byp_vld is cleared by any accepted op other than PUSH.
- State machine:
  - IDLE: accepts ops.
  - FILL: bsy_o=1. ss_ren=1 and ss_raddr=sp are re-driven every cycle.
  - FILL → IDLE on the first cycle with en=1, capturing s<=rd_data_i. With en=0 the FILL state holds.
- Error flags:
  - err_clr clears ovf and unf.
  - If an error occurs in the same cycle as err_clr, the set wins.
- Invariant: ss_raddr never equals ss_waddr while both enables are high. The bypass guarantees this, and a bench assertion checks it.

## Timing
- Reset values: sp=0, depth_o=0, s_o=0, byp_vld=0, state IDLE, bsy_o=0, ovf_o=0, unf_o=0, full_o=0, empty_o=1, ss_ren=0, ss_wen=0.
- ss_wen, ss_ren, addresses and ss_wdata are combinational from the accepted op and the current registers. The EBR samples them on the same edge.
- Latencies:
  - PUSH: s_o updates 1 cycle after accept.
  - POP with bypass or depth==1: s_o updates after 1 cycle.
  - POP with refill: bsy_o is high for exactly 1 cycle when en stays high, and s_o is valid 2 cycles after accept.
- rst during FILL returns to IDLE immediately. Any pending read data is discarded.

## Test plan
- Reset then PUSH 0x11, 0x22, 0x33 with en=1: depth_o goes 1, 2, 3; s_o=0x33; EBR holds [0]=0x11 and [1]=0x22; bsy_o is never high.
- Continuing from the previous scenario, POP: s_o=0x22 next cycle via bypass with no ss_ren. A second POP raises bsy_o for one cycle, then s_o=0x11 and depth_o=1.
- PUSH SS_DEPTH+1 values 1..33: full_o=1. A 34th PUSH sets ovf_o and leaves depth_o=33 and s_o=33. err_clr then drops ovf_o next cycle.
- POP from empty: unf_o=1 and depth_o stays 0. err_clr asserted together with another empty POP keeps unf_o=1.
- SWAP with t_i=0xAA while s_o=0x55: s_o=0xAA next cycle; depth and sp unchanged.
- Refill POP with en deasserted for 3 cycles during FILL: bsy_o stays high, and s_o takes the correct EBR value on the first en=1 cycle. rst asserted mid-FILL returns all outputs to their reset values.

Source files
------------

// File: rtl/ej32_ss_ctl.sv
`default_nettype none
// ============================================================================
// ej32_ss_ctl : eJ32 data-stack controller (NOS cache, EBR ports, bypass)
// Rev 1.0
// ============================================================================
module ej32_ss_ctl #(
   parameter int SS_DEPTH = 32,
   parameter int ASZ      = 5,
   parameter int DSZ      = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [1:0]     op_i,
   input  logic [DSZ-1:0] t_i,
   input  logic           err_clr,
   input  logic [DSZ-1:0] rd_data_i,
   output logic           ss_ren,
   output logic           ss_wen,
   output logic [ASZ-1:0] ss_raddr,
   output logic [ASZ-1:0] ss_waddr,
   output logic [DSZ-1:0] ss_wdata,
   output logic [DSZ-1:0] s_o,
   output logic           bsy_o,
   output logic [ASZ:0]   depth_o,
   output logic           full_o,
   output logic           empty_o,
   output logic           ovf_o,
   output logic           unf_o
);

   localparam logic [1:0]   c_op_nop  = 2'd0;
   localparam logic [1:0]   c_op_push = 2'd1;
   localparam logic [1:0]   c_op_pop  = 2'd2;
   localparam logic [1:0]   c_op_swap = 2'd3;
   localparam logic [ASZ:0] c_one     = (ASZ+1)'(1);
   localparam logic [ASZ:0] c_full    = (ASZ+1)'(SS_DEPTH + 1);
   localparam logic [ASZ-1:0] c_a_one = ASZ'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [ASZ:0]   sp_q, sp_d;
   logic [ASZ:0]   depth_q, depth_d;
   logic [DSZ-1:0] s_q, s_d;
   logic [DSZ-1:0] byp_q, byp_d;
   logic           byp_vld_q, byp_vld_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;

   logic           w_accept;
   logic           w_full;
   logic           w_empty;

   assign w_full   = (depth_q == c_full);
   assign w_empty  = (depth_q == '0);
   assign w_accept = en && (state_q == ST_IDLE) && (op_i != c_op_nop);

   always_comb begin
      state_d   = state_q;
      sp_d      = sp_q;
      depth_d   = depth_q;
      s_d       = s_q;
      byp_d     = byp_q;
      byp_vld_d = byp_vld_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      ss_ren    = 1'b0;
      ss_wen    = 1'b0;
      ss_raddr  = sp_q[ASZ-1:0];
      ss_waddr  = sp_q[ASZ-1:0];
      ss_wdata  = s_q;

      // Clear first so a same-cycle error below overrides it.
      if (en && err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end

      case (state_q)
         ST_FILL: begin
            // Keep the read asserted so the data is still there after an en stall.
            ss_ren   = 1'b1;
            ss_raddr = sp_q[ASZ-1:0];
            if (en) begin
               s_d     = rd_data_i;
               state_d = ST_IDLE;
            end
         end
         default: begin
            if (w_accept) begin
               case (op_i)
                  c_op_push: begin
                     if (w_full) begin
                        ovf_d = 1'b1;
                     end else begin
                        if (!w_empty) begin
                           ss_wen    = 1'b1;
                           sp_d      = sp_q + c_one;
                           byp_d     = s_q;
                           byp_vld_d = 1'b1;
                        end
                        s_d     = t_i;
                        depth_d = depth_q + c_one;
                     end
                  end
                  c_op_pop: begin
                     byp_vld_d = 1'b0;
                     if (w_empty) begin
                        unf_d = 1'b1;
                     end else if (depth_q == c_one) begin
                        depth_d = '0;
                        s_d     = '0;
                     end else if (byp_vld_q) begin
                        s_d     = byp_q;
                        sp_d    = sp_q - c_one;
                        depth_d = depth_q - c_one;
                     end else begin
                        ss_ren   = 1'b1;
                        ss_raddr = sp_q[ASZ-1:0] - c_a_one;
                        sp_d     = sp_q - c_one;
                        depth_d  = depth_q - c_one;
                        state_d  = ST_FILL;
                     end
                  end
                  c_op_swap: begin
                     s_d       = t_i;
                     byp_vld_d = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sp_q      <= '0;
         depth_q   <= '0;
         s_q       <= '0;
         byp_q     <= '0;
         byp_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sp_q      <= sp_d;
         depth_q   <= depth_d;
         s_q       <= s_d;
         byp_q     <= byp_d;
         byp_vld_q <= byp_vld_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign s_o     = s_q;
   assign bsy_o   = (state_q == ST_FILL);
   assign depth_o = depth_q;
   assign full_o  = w_full;
   assign empty_o = w_empty;
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_ej32_ss_ctl.sv
`default_nettype none
// ============================================================================
// tb_ej32_ss_ctl : vector table + scoreboard bench for ej32_ss_ctl
// Rev 1.0
// ============================================================================
module tb_ej32_ss_ctl;

   localparam int SS_DEPTH = 32;
   localparam int ASZ      = 5;
   localparam int DSZ      = 32;

   localparam logic [1:0] NOP  = 2'd0;
   localparam logic [1:0] PUSH = 2'd1;
   localparam logic [1:0] POP  = 2'd2;
   localparam logic [1:0] SWAP = 2'd3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b0;
   logic [1:0]     op_i = 2'd0;
   logic [DSZ-1:0] t_i = '0;
   logic           err_clr = 1'b0;
   logic [DSZ-1:0] rd_data_i;
   logic           ss_ren, ss_wen;
   logic [ASZ-1:0] ss_raddr, ss_waddr;
   logic [DSZ-1:0] ss_wdata, s_o;
   logic           bsy_o, full_o, empty_o, ovf_o, unf_o;
   logic [ASZ:0]   depth_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ej32_ss_ctl #(.SS_DEPTH(SS_DEPTH), .ASZ(ASZ), .DSZ(DSZ)) dut (
      .clk(clk), .rst(rst), .en(en), .op_i(op_i), .t_i(t_i), .err_clr(err_clr),
      .rd_data_i(rd_data_i), .ss_ren(ss_ren), .ss_wen(ss_wen),
      .ss_raddr(ss_raddr), .ss_waddr(ss_waddr), .ss_wdata(ss_wdata),
      .s_o(s_o), .bsy_o(bsy_o), .depth_o(depth_o), .full_o(full_o),
      .empty_o(empty_o), .ovf_o(ovf_o), .unf_o(unf_o)
   );

   // Dual-port EBR model with one-cycle registered read.
   logic [DSZ-1:0] mem [SS_DEPTH];
   always @(posedge clk) begin
      if (ss_wen) mem[ss_waddr] <= ss_wdata;
      if (ss_ren) rd_data_i <= mem[ss_raddr];
   end

   always @(posedge clk) begin
      if (!rst && ss_ren && ss_wen)
         assert (ss_raddr != ss_waddr) else $error("raddr equals waddr with both enables high");
   end

   typedef struct {
      logic           rst;
      logic           en;
      logic [1:0]     op;
      logic [DSZ-1:0] t;
      logic           clr;
      logic           x_ren;
      logic           x_wen;
      logic [ASZ-1:0] x_addr;
      logic [DSZ-1:0] x_wd;
      logic [DSZ-1:0] x_s;
      logic [ASZ:0]   x_d;
      logic           x_bsy;
      logic           x_ovf;
      logic           x_unf;
   } vec_t;

   typedef struct {
      logic [DSZ-1:0] s;
      logic [ASZ:0]   d;
      logic           bsy;
      logic           ovf;
      logic           unf;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   function automatic vec_t mk(logic r, logic e, logic [1:0] op, logic [DSZ-1:0] t, logic c,
                               logic ren, logic wen, int addr, logic [DSZ-1:0] wd,
                               logic [DSZ-1:0] s, int d, logic b, logic o, logic u);
      vec_t v;
      v.rst = r; v.en = e; v.op = op; v.t = t; v.clr = c;
      v.x_ren = ren; v.x_wen = wen; v.x_addr = ASZ'(addr); v.x_wd = wd;
      v.x_s = s; v.x_d = (ASZ+1)'(d); v.x_bsy = b; v.x_ovf = o; v.x_unf = u;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      rst = v.rst; en = v.en; op_i = v.op; t_i = v.t; err_clr = v.clr;
      #1;
      chk("ss_ren", 64'(ss_ren), 64'(v.x_ren));
      chk("ss_wen", 64'(ss_wen), 64'(v.x_wen));
      if (v.x_ren) chk("ss_raddr", 64'(ss_raddr), 64'(v.x_addr));
      if (v.x_wen) begin
         chk("ss_waddr", 64'(ss_waddr), 64'(v.x_addr));
         chk("ss_wdata", 64'(ss_wdata), 64'(v.x_wd));
      end
      e.s = v.x_s; e.d = v.x_d; e.bsy = v.x_bsy; e.ovf = v.x_ovf; e.unf = v.x_unf;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk("s_o", 64'(s_o), 64'(e.s));
         chk("depth_o", 64'(depth_o), 64'(e.d));
         chk("bsy_o", 64'(bsy_o), 64'(e.bsy));
         chk("ovf_o", 64'(ovf_o), 64'(e.ovf));
         chk("unf_o", 64'(unf_o), 64'(e.unf));
         chk("full_o", 64'(full_o), 64'(e.d == (ASZ+1)'(SS_DEPTH + 1)));
         chk("empty_o", 64'(empty_o), 64'(e.d == '0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //        rst en op    t        clr ren wen addr wd       s         d  bsy ovf unf
      tbl.push_back(mk(1, 1, NOP,  0,       0, 0, 0, 0, 0,       0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 1, PUSH, 32'h11,  0, 0, 0, 0, 0,       32'h11,   1, 0, 0, 0));
      tbl.push_back(mk(0, 1, PUSH, 32'h22,  0, 0, 1, 0, 32'h11,  32'h22,   2, 0, 0, 0));
      tbl.push_back(mk(0, 1, PUSH, 32'h33,  0, 0, 1, 1, 32'h22,  32'h33,   3, 0, 0, 0));
      tbl.push_back(mk(0, 1, POP,  0,       0, 0, 0, 0, 0,       32'h22,   2, 0, 0, 0));
      tbl.push_back(mk(0, 1, POP,  0,       0, 1, 0, 0, 0,       32'h22,   1, 1, 0, 0));
      tbl.push_back(mk(0, 1, PUSH, 32'h99,  0, 1, 0, 0, 0,       32'h11,   1, 0, 0, 0));
      tbl.push_back(mk(0, 0, PUSH, 32'h77,  0, 0, 0, 0, 0,       32'h11,   1, 0, 0, 0));
      tbl.push_back(mk(0, 1, PUSH, 32'h55,  0, 0, 1, 0, 32'h11,  32'h55,   2, 0, 0, 0));
      tbl.push_back(mk(0, 1, SWAP, 32'hAA,  0, 0, 0, 0, 0,       32'hAA,   2, 0, 0, 0));
      tbl.push_back(mk(0, 1, POP,  0,       0, 1, 0, 0, 0,       32'hAA,   1, 1, 0, 0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, 0, NOP, 0,     0, 1, 0, 0, 0,       32'hAA,   1, 1, 0, 0));
      tbl.push_back(mk(0, 1, NOP,  0,       0, 1, 0, 0, 0,       32'h11,   1, 0, 0, 0));
      tbl.push_back(mk(0, 1, POP,  0,       0, 0, 0, 0, 0,       0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 1, POP,  0,       0, 0, 0, 0, 0,       0,        0, 0, 0, 1));
      tbl.push_back(mk(0, 1, POP,  0,       1, 0, 0, 0, 0,       0,        0, 0, 0, 1));
      tbl.push_back(mk(0, 1, NOP,  0,       1, 0, 0, 0, 0,       0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 1, PUSH, 1,       0, 0, 0, 0, 0,       1,        1, 0, 0, 0));
      tbl.push_back(mk(0, 1, PUSH, 2,       0, 0, 1, 0, 1,       2,        2, 0, 0, 0));
      tbl.push_back(mk(0, 1, PUSH, 3,       0, 0, 1, 1, 2,       3,        3, 0, 0, 0));
      tbl.push_back(mk(0, 1, POP,  0,       0, 0, 0, 0, 0,       2,        2, 0, 0, 0));
      tbl.push_back(mk(0, 1, POP,  0,       0, 1, 0, 0, 0,       2,        1, 1, 0, 0));
      tbl.push_back(mk(1, 1, NOP,  0,       0, 1, 0, 0, 0,       0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 1, NOP,  0,       0, 0, 0, 0, 0,       0,        0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         if (i == 3) begin
            chk("ebr[0]", 64'(mem[0]), 64'h11);
            chk("ebr[1]", 64'(mem[1]), 64'h22);
         end
      end

      // Fill to capacity, overflow, clear, then unwind through bypass and refill.
      apply(mk(1, 1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 1; k <= SS_DEPTH + 1; k++)
         apply(mk(0, 1, PUSH, DSZ'(k), 0, 0, k >= 2, k - 2, DSZ'(k - 1), DSZ'(k), k, 0, 0, 0));
      apply(mk(0, 1, PUSH, 34, 0, 0, 0, 0, 0, 33, 33, 0, 1, 0));
      apply(mk(0, 1, NOP,  0,  1, 0, 0, 0, 0, 33, 33, 0, 0, 0));
      apply(mk(0, 1, POP,  0,  0, 0, 0, 0, 0, 32, 32, 0, 0, 0));
      apply(mk(0, 1, POP,  0,  0, 1, 0, 30, 0, 32, 31, 1, 0, 0));
      apply(mk(0, 1, NOP,  0,  0, 1, 0, 30, 0, 31, 31, 0, 0, 0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
